// File: rtl/net_tx_retransmit.sv
// ---------------------------------------------------------------------------
// net_tx_retransmit
//
// Reliable transmit stage sitting after the ASP network output. Tagged words
// are queued in a FIFO; the head word is offered on the link with a
// valid/ready handshake and held until the far end ACKs it. If no ACK arrives
// within TIMEOUT cycles the word is resent, up to MAX_RETRY times, after which
// it is dropped and fail_out pulses.
//
// Ports (W = DATA_SIZE+TAG_SIZE, AW = $clog2(DEPTH))
//   clk              in   1      clock, rising edge
//   reset            in   1      asynchronous, active-low
//   in_valid         in   1      push request from ASP
//   in_data_tag      in   W      word to queue
//   link_ready       in   1      link accepts link_data_tag this cycle
//   link_ack_in      in   1      single-cycle ACK for the outstanding word
//   link_valid       out  1      link_data_tag is valid
//   link_data_tag    out  W      head-of-queue word (0 when FIFO empty)
//   overflow_out     out  1      pulse: push dropped, FIFO full
//   fail_out         out  1      pulse: head dropped after MAX_RETRY retries
//   fifo_count       out  AW+1   occupied entries
//   busy_out         out  1      FSM not in IDLE
//   retry_count_out  out  CNT_W  saturating timeout-retransmission count
//   drop_count_out   out  CNT_W  saturating fail_out count
//
// Build option: define RETRY_STATS_EN to add retry_count_out/drop_count_out.
// ---------------------------------------------------------------------------
module net_tx_retransmit #(
    parameter int DATA_SIZE = 32,
    parameter int TAG_SIZE  = 8,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [DATA_SIZE+TAG_SIZE-1:0]  in_data_tag,
    input  logic                           link_ready,
    input  logic                           link_ack_in,
    output logic                           link_valid,
    output logic [DATA_SIZE+TAG_SIZE-1:0]  link_data_tag,
    output logic                           overflow_out,
    output logic                           fail_out,
    output logic [$clog2(DEPTH):0]         fifo_count,
    output logic                           busy_out
`ifdef RETRY_STATS_EN
    ,
    output logic [CNT_W-1:0]               retry_count_out,
    output logic [CNT_W-1:0]               drop_count_out
`endif
);

    localparam int W  = DATA_SIZE + TAG_SIZE;
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RMAX    = RW'(MAX_RETRY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2 || CNT_W < 1) begin : g_param_chk
        $error("net_tx_retransmit: illegal parameter set");
    end

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic [W-1:0]  r_head;
    logic          r_head_vld;
    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_retry;
    logic          r_fail, r_ovf;

    logic w_ack, w_tmo, w_drop, w_pop, w_push, w_last;

    // ACK beats a coincident timeout, so the timeout term is masked by it.
    assign w_ack  = (r_state == S_WAIT) && link_ack_in;
    assign w_tmo  = (r_state == S_WAIT) && !link_ack_in && (r_timer == TMAX);
    assign w_drop = w_tmo && (r_retry == RMAX);
    assign w_pop  = w_ack || w_drop;
    // A full FIFO can still accept a word in the cycle its head retires.
    assign w_push = in_valid && ((r_count != DEPTH_C) || w_pop);
    // The pop empties the queue (no refill in the same cycle).
    assign w_last = w_pop && !w_push && (r_count == (AW+1)'(1));

    // Storage carries no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= in_data_tag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Head register follows mem[r_rptr] one cycle behind the pointers.
    // r_head_vld marks that r_head has been loaded for a non-empty queue; IDLE
    // waits on it, which gives the two-cycle push-to-valid latency from empty
    // while letting a queued follower launch one cycle after retirement (its
    // head load and the IDLE->SEND step land on the same edge).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_head_vld <= 1'b0;
        end else begin
            r_head_vld <= (r_count != '0) && !w_last;
            r_head     <= ((r_count != '0) && !w_last) ? r_mem[r_rptr] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_retry <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if ((r_count != '0) && r_head_vld) r_state <= S_SEND;
                end
                S_SEND: begin
                    if (link_ready) begin
                        r_state <= S_WAIT;
                        r_timer <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_pop) begin
                        r_state <= S_IDLE;
                        r_retry <= '0;
                        r_timer <= '0;
                    end else if (w_tmo) begin
                        r_state <= S_SEND;
                        r_retry <= r_retry + 1'b1;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    r_retry <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fail <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_fail <= w_drop;
            r_ovf  <= in_valid && !w_push;
        end
    end

`ifdef RETRY_STATS_EN
    logic [CNT_W-1:0] r_retry_cnt, r_drop_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retry_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_tmo && !w_drop && (r_retry_cnt != '1)) r_retry_cnt <= r_retry_cnt + 1'b1;
            if (w_drop && (r_drop_cnt != '1))            r_drop_cnt  <= r_drop_cnt + 1'b1;
        end
    end

    assign retry_count_out = r_retry_cnt;
    assign drop_count_out  = r_drop_cnt;
`endif

    assign link_valid    = (r_state == S_SEND);
    assign busy_out      = (r_state != S_IDLE);
    assign link_data_tag = r_head;
    assign fifo_count    = r_count;
    assign overflow_out  = r_ovf;
    assign fail_out      = r_fail;

endmodule

// File: tb/tb_net_tx_retransmit.sv
module tb_net_tx_retransmit;
    localparam int W = 40;

    logic         clk = 1'b0, reset = 1'b0;
    logic         in_valid = 1'b0, link_ready = 1'b0, link_ack_in = 1'b0;
    logic [W-1:0] in_data_tag = '0;
    logic         link_valid, overflow_out, fail_out, busy_out;
    logic [W-1:0] link_data_tag;
    logic [3:0]   fifo_count;
`ifdef RETRY_STATS_EN
    logic [15:0]  retry_count_out, drop_count_out;
`endif

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_data[$];
    int obs_cyc[$], fail_cyc[$], ovf_cyc[$];

    net_tx_retransmit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data_tag(in_data_tag),
        .link_ready(link_ready), .link_ack_in(link_ack_in), .link_valid(link_valid),
        .link_data_tag(link_data_tag), .overflow_out(overflow_out), .fail_out(fail_out),
        .fifo_count(fifo_count), .busy_out(busy_out)
`ifdef RETRY_STATS_EN
        , .retry_count_out(retry_count_out), .drop_count_out(drop_count_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observe on the falling edge; a handshake seen here completes at edge cyc+1.
    always @(negedge clk) begin
        if (reset) begin
            if (link_valid && link_ready) begin
                obs_data.push_back(link_data_tag);
                obs_cyc.push_back(cyc + 1);
            end
            if (fail_out)     fail_cyc.push_back(cyc);
            if (overflow_out) ovf_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        in_valid = 0; link_ready = 0; link_ack_in = 0;
        reset = 0; tick(); tick(); reset = 1;
        exp_q.delete(); obs_data.delete(); obs_cyc.delete();
        fail_cyc.delete(); ovf_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 0; in_valid = 1; link_ack_in = 1; in_data_tag = 40'hDEADBEEF01;
        tick(); tick();
        n_chk++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL rst_link_valid: got %0h expected 0", link_valid); end
        n_chk++; if (link_data_tag !== '0) begin n_fail++; $display("FAIL rst_link_data: got %0h expected 0", link_data_tag); end
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rst_fifo_count: got %0d expected 0", fifo_count); end
        n_chk++; if ({overflow_out, fail_out, busy_out} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses_busy: got %b expected 000", {overflow_out, fail_out, busy_out}); end
        link_ack_in = 0; reset = 1;
        tick();  // in_valid still high: this edge pushes
        n_chk++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL rel_link_valid: got %0h expected 0", link_valid); end
        n_chk++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL rel_fifo_count: got %0d expected 1", fifo_count); end
        in_valid = 0;
        do_reset();
    endtask

    task automatic test_single_ack();
        int pe, lv, h, k;
        logic [W-1:0] e;
        do_reset();
        link_ready = 1;
        in_data_tag = 40'h12345678A5; in_valid = 1; exp_q.push_back(40'h12345678A5);
        tick(); in_valid = 0; pe = cyc;
        lv = -1;
        for (k = 0; k < 10 && lv < 0; k++) begin
            if (link_valid === 1'b1) lv = cyc; else tick();
        end
        n_chk++; if (lv - pe != 2) begin n_fail++; $display("FAIL push_to_valid: got %0d expected 2", lv - pe); end
        n_chk++; if (link_data_tag !== 40'h12345678A5) begin n_fail++; $display("FAIL head_word: got %0h expected 12345678a5", link_data_tag); end
        for (k = 0; k < 10 && obs_cyc.size() == 0; k++) tick();
        if (obs_cyc.size() == 0) begin
            n_chk++; n_fail++; $display("FAIL single_hs_timeout: got 0 handshakes expected 1");
        end else begin
            h = obs_cyc[0];
            while (cyc < h + 2) tick();
            link_ack_in = 1; tick(); link_ack_in = 0;
        end
        repeat (80) tick();
        n_chk++; if (obs_data.size() != 1) begin n_fail++; $display("FAIL single_hs_count: got %0d expected 1", obs_data.size()); end
        if (obs_data.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++; if (obs_data[0] !== e) begin n_fail++; $display("FAIL single_hs_data: got %0h expected %0h", obs_data[0], e); end
        end
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL single_count: got %0d expected 0", fifo_count); end
        n_chk++; if (fail_cyc.size() != 0) begin n_fail++; $display("FAIL single_fail: got %0d pulses expected 0", fail_cyc.size()); end
        link_ready = 0;
    endtask

    task automatic test_timeout_drop();
        int k;
        logic [W-1:0] e;
        do_reset();
        link_ready = 1;
        in_data_tag = 40'h00CAFE0042; in_valid = 1; exp_q.push_back(40'h00CAFE0042);
        tick(); in_valid = 0;
        for (k = 0; k < 400 && fail_cyc.size() == 0; k++) tick();
        repeat (5) tick();
        n_chk++; if (obs_cyc.size() != 4) begin n_fail++; $display("FAIL retry_hs_count: got %0d expected 4", obs_cyc.size()); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        for (int i = 0; i < obs_cyc.size(); i++) begin
            n_chk++; if (obs_data[i] !== e) begin n_fail++; $display("FAIL retry_data[%0d]: got %0h expected %0h", i, obs_data[i], e); end
            if (i > 0) begin
                n_chk++; if (obs_cyc[i] - obs_cyc[i-1] != 65) begin n_fail++; $display("FAIL retry_gap[%0d]: got %0d expected 65", i, obs_cyc[i] - obs_cyc[i-1]); end
            end
        end
        n_chk++; if (fail_cyc.size() != 1) begin n_fail++; $display("FAIL fail_pulses: got %0d expected 1", fail_cyc.size()); end
        if (fail_cyc.size() > 0 && obs_cyc.size() == 4) begin
            n_chk++; if (fail_cyc[0] != obs_cyc[3] + 64) begin n_fail++; $display("FAIL fail_time: got %0d expected %0d", fail_cyc[0], obs_cyc[3] + 64); end
        end
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL drop_count: got %0d expected 0", fifo_count); end
        n_chk++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %0h expected 0", busy_out); end
        link_ready = 0;
    endtask

    task automatic test_overflow_order();
        int p9, k, seen;
        logic [W-1:0] e;
        do_reset();
        in_valid = 1;
        for (int i = 1; i <= 9; i++) begin
            in_data_tag = W'(i);
            if (i <= 8) exp_q.push_back(W'(i));
            tick();
        end
        in_valid = 0; p9 = cyc;
        n_chk++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", fifo_count); end
        tick();
        n_chk++; if (ovf_cyc.size() != 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d expected 1", ovf_cyc.size()); end
        if (ovf_cyc.size() > 0) begin
            n_chk++; if (ovf_cyc[0] != p9) begin n_fail++; $display("FAIL ovf_time: got %0d expected %0d", ovf_cyc[0], p9); end
        end
        // Drain: ACK in the cycle right after each handshake.
        link_ready = 1; seen = 0;
        for (k = 0; k < 300 && seen < 8; k++) begin
            tick();
            link_ack_in = 0;
            if (obs_cyc.size() > seen && obs_cyc[obs_cyc.size()-1] == cyc) begin
                link_ack_in = 1; seen++;
            end
        end
        tick(); link_ack_in = 0; repeat (5) tick();
        n_chk++; if (obs_data.size() != 8) begin n_fail++; $display("FAIL drain_hs_count: got %0d expected 8", obs_data.size()); end
        for (int i = 0; i < obs_data.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            n_chk++; if (obs_data[i] !== e) begin n_fail++; $display("FAIL drain_order[%0d]: got %0h expected %0h", i, obs_data[i], e); end
            if (i > 0) begin
                n_chk++; if (obs_cyc[i] - obs_cyc[i-1] != 3) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d expected 3", i, obs_cyc[i] - obs_cyc[i-1]); end
            end
        end
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", fifo_count); end
        n_chk++; if (link_data_tag !== '0) begin n_fail++; $display("FAIL empty_head: got %0h expected 0", link_data_tag); end
        link_ready = 0;
    endtask

    task automatic test_ack_at_timeout();
        int k, h;
        do_reset();
        link_ready = 1;
        in_data_tag = 40'h55AA55AA77; in_valid = 1; exp_q.push_back(40'h55AA55AA77);
        tick(); in_valid = 0;
        for (k = 0; k < 10 && obs_cyc.size() == 0; k++) tick();
        if (obs_cyc.size() == 0) begin
            n_chk++; n_fail++; $display("FAIL race_hs_timeout: got 0 handshakes expected 1");
        end else begin
            h = obs_cyc[0];
            while (cyc < h + 63) tick();
            link_ack_in = 1; tick(); link_ack_in = 0;  // sampled with timer at TIMEOUT-1
        end
        repeat (100) tick();
        n_chk++; if (obs_cyc.size() != 1) begin n_fail++; $display("FAIL race_hs_count: got %0d expected 1", obs_cyc.size()); end
        n_chk++; if (fail_cyc.size() != 0) begin n_fail++; $display("FAIL race_fail: got %0d pulses expected 0", fail_cyc.size()); end
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL race_count: got %0d expected 0", fifo_count); end
        link_ready = 0;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        link_ready = 1;
        in_data_tag = 40'h0000000AB1; in_valid = 1; tick();
        in_data_tag = 40'h0000000AB2; tick();
        in_data_tag = 40'h0000000AB3; tick();
        in_valid = 0;
        repeat (10) tick();  // first word outstanding in WAIT_ACK
        n_chk++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %0h expected 1", busy_out); end
        #2 reset = 0; #1;
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL mid_async_count: got %0d expected 0", fifo_count); end
        n_chk++; if ({link_valid, busy_out} !== 2'b00) begin n_fail++; $display("FAIL mid_async_state: got %b expected 00", {link_valid, busy_out}); end
        tick(); reset = 1;
        repeat (100) tick();
        n_chk++; if (fail_cyc.size() != 0) begin n_fail++; $display("FAIL mid_fail: got %0d pulses expected 0", fail_cyc.size()); end
        n_chk++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL mid_link_valid: got %0h expected 0", link_valid); end
        link_ready = 0;
    endtask

`ifdef RETRY_STATS_EN
    task automatic test_stats();
        test_timeout_drop();
        n_chk++; if (retry_count_out !== 16'd3) begin n_fail++; $display("FAIL stat_retry: got %0d expected 3", retry_count_out); end
        n_chk++; if (drop_count_out !== 16'd1) begin n_fail++; $display("FAIL stat_drop: got %0d expected 1", drop_count_out); end
        #2 reset = 0; #1;
        n_chk++; if ({retry_count_out, drop_count_out} !== 32'd0) begin n_fail++; $display("FAIL stat_reset: got %0h expected 0", {retry_count_out, drop_count_out}); end
        tick(); reset = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_ack();
        test_timeout_drop();
        test_overflow_order();
        test_ack_at_timeout();
        test_reset_midrun();
`ifdef RETRY_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
